mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Purpose: MEM pipeline stage -- data-memory handshake, branch resolve, MEM/WB register.
// Latency: 1 cycle to MEM/WB for non-memory ops; memory ops complete on dm_ack, timeout after TIMEOUT wait cycles.
// Backpressure: stall holds upstream while a memory access waits for dm_ack; MEM/WB takes bubbles meanwhile.
module mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  WB_in,
  input  logic [2:0]  MEM_in,
  input  logic [31:0] add_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] RD2_in,
  input  logic [4:0]  WN_in,
  input  logic        z_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall,
  output logic        pcsrc,
  output logic [31:0] br_target,
  output logic [1:0]  WB_out,
  output logic [31:0] RD_out,
  output logic [31:0] alu_out,
  output logic [4:0]  WN_out,
  output logic        addr_err,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic mem_op, aligned, access, misaligned;
  logic in_wait, expired, is_read, bubble, ack_seen;

  // Decode the memory operation; a simultaneous read+write is treated as a write.
  always_comb begin
    mem_op     = MEM_in[1] | MEM_in[0];
    aligned    = (alu_in[1:0] == 2'b00);
    access     = mem_op & aligned;
    misaligned = mem_op & ~aligned;
    is_read    = MEM_in[1] & ~MEM_in[0];
    in_wait    = (state == S_WAIT);
  end

  // Memory request and stall; reset gates both so an aborted access drops at once.
  always_comb begin
    dm_req   = rst & (in_wait | access);
    dm_we    = MEM_in[0] & dm_req;
    dm_addr  = alu_in;
    dm_wdata = RD2_in;
    ack_seen = dm_ack & dm_req;
    // An ack on the last allowed wait cycle wins over the timeout.
    expired  = rst & in_wait & ~dm_ack & (cnt == CNT_MAX);
    stall    = dm_req & ~dm_ack & ~expired;
    // Misalignment is only possible for a freshly sampled instruction, i.e. in IDLE.
    bubble   = stall | expired | (misaligned & ~in_wait);
  end

  // Branch resolution is purely combinational and ignores the access FSM.
  always_comb begin
    pcsrc     = MEM_in[2] & z_in;
    br_target = add_in;
  end

  // Next-state and wait counter: cnt holds the number of wait cycles already spent.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (access && !dm_ack) begin
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      S_WAIT: begin
        if (dm_ack || expired) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // MEM/WB register: loads every cycle; a bubble only clears the write-back controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WB_out   <= 2'b00;
      RD_out   <= 32'h0;
      alu_out  <= 32'h0;
      WN_out   <= 5'd0;
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      WB_out   <= bubble ? 2'b00 : WB_in;
      RD_out   <= (is_read && ack_seen) ? dm_rdata : 32'h0;
      alu_out  <= alu_in;
      WN_out   <= WN_in;
      addr_err <= misaligned & ~in_wait;
      bus_err  <= expired;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Purpose: randomized + directed bench for mem_stage with a queue-based scoreboard.
// Latency: expectations for combinational outputs are checked mid-cycle, MEM/WB just after the edge.
// Backpressure: the driver holds each instruction for as many cycles as the reference model predicts.
`timescale 1ns/1ps
module tb_mem_stage;

  localparam int TO = 15;

  typedef struct packed {
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pcsrc;
    logic [31:0] tgt;
  } comb_t;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wn;
    logic        aerr;
    logic        berr;
  } reg_t;

  logic        clk, rst;
  logic [1:0]  WB_in;
  logic [2:0]  MEM_in;
  logic [31:0] add_in, alu_in, RD2_in;
  logic [4:0]  WN_in;
  logic        z_in;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ack;
  logic        stall, pcsrc;
  logic [31:0] br_target;
  logic [1:0]  WB_out;
  logic [31:0] RD_out, alu_out;
  logic [4:0]  WN_out;
  logic        addr_err, bus_err;

  comb_t cq[$];
  reg_t  rq[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .WB_in(WB_in), .MEM_in(MEM_in), .add_in(add_in), .alu_in(alu_in),
    .RD2_in(RD2_in), .WN_in(WN_in), .z_in(z_in),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .stall(stall), .pcsrc(pcsrc), .br_target(br_target),
    .WB_out(WB_out), .RD_out(RD_out), .alu_out(alu_out), .WN_out(WN_out),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: one instruction is held until the access resolves.
  // An access with ack latency lat lasts min(lat,TO)+1 cycles; stall is high in all but the last.
  task automatic issue(input logic [1:0] wb, input logic [2:0] mem, input logic [31:0] add,
                       input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] wn,
                       input logic z, input int lat, input logic [31:0] rdat);
    logic  mem_op, mis, acc, done;
    logic [1:0] lo;
    int    n;
    comb_t c;
    reg_t  r;
    lo     = alu[1:0];
    mem_op = mem[1] | mem[0];
    mis    = mem_op && (lo != 2'b00);
    acc    = mem_op && (lo == 2'b00);
    n      = acc ? ((lat < TO) ? lat : TO) : 0;
    done   = (lat <= TO);
    for (int k = 0; k <= n; k++) begin
      @(posedge clk); #2;
      WB_in = wb; MEM_in = mem; add_in = add; alu_in = alu; RD2_in = rd2; WN_in = wn; z_in = z;
      dm_rdata = rdat;
      dm_ack   = acc ? (k == lat) : 1'($urandom_range(0, 1));
      c.stall = acc && (k < n);
      c.req   = acc;
      c.we    = acc && mem[0];
      c.addr  = alu;
      c.wdata = rd2;
      c.pcsrc = mem[2] & z;
      c.tgt   = add;
      cq.push_back(c);
      r.alu  = alu;
      r.wn   = wn;
      r.aerr = 1'b0;
      r.berr = 1'b0;
      r.rd   = 32'h0;
      r.wb   = 2'b00;
      if (!acc) begin
        r.wb   = mis ? 2'b00 : wb;
        r.aerr = mis;
      end else if (k == n) begin
        if (done) begin
          r.wb = wb;
          r.rd = (mem == 3'b010 || mem == 3'b110) ? rdat : 32'h0;
        end else begin
          r.berr = 1'b1;
        end
      end
      rq.push_back(r);
    end
  endtask

  // Monitor for combinational outputs, sampled mid-cycle.
  initial begin
    comb_t c;
    forever begin
      @(negedge clk);
      if (cq.size() != 0) begin
        c = cq.pop_front();
        chk("stall",     32'(stall),  32'(c.stall));
        chk("dm_req",    32'(dm_req), 32'(c.req));
        chk("dm_we",     32'(dm_we),  32'(c.we));
        chk("dm_addr",   dm_addr,     c.addr);
        chk("dm_wdata",  dm_wdata,    c.wdata);
        chk("pcsrc",     32'(pcsrc),  32'(c.pcsrc));
        chk("br_target", br_target,   c.tgt);
      end
    end
  end

  // Monitor for the MEM/WB register, sampled just after the edge.
  initial begin
    reg_t r;
    forever begin
      @(posedge clk); #1;
      if (rq.size() != 0) begin
        r = rq.pop_front();
        chk("WB_out",   32'(WB_out),   32'(r.wb));
        chk("RD_out",   RD_out,        r.rd);
        chk("alu_out",  alu_out,       r.alu);
        chk("WN_out",   32'(WN_out),   32'(r.wn));
        chk("addr_err", 32'(addr_err), 32'(r.aerr));
        chk("bus_err",  32'(bus_err),  32'(r.berr));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  m;
    int          sel, lat;
    rst = 1'b1;
    WB_in = 0; MEM_in = 0; add_in = 0; alu_in = 0; RD2_in = 0; WN_in = 0; z_in = 0;
    dm_rdata = 0; dm_ack = 0;
    #1 rst = 1'b0;
    #2;
    chk("rst_WB_out",   32'(WB_out),   32'h0);
    chk("rst_RD_out",   RD_out,        32'h0);
    chk("rst_alu_out",  alu_out,       32'h0);
    chk("rst_WN_out",   32'(WN_out),   32'h0);
    chk("rst_addr_err", 32'(addr_err), 32'h0);
    chk("rst_bus_err",  32'(bus_err),  32'h0);
    chk("rst_stall",    32'(stall),    32'h0);
    @(negedge clk); rst = 1'b1;

    // Directed cases
    issue(2'b11, 3'b010, 32'h0,    32'h100, 32'h0,    5'd5, 1'b0, 0,   32'hDEADBEEF); // zero-wait load
    issue(2'b00, 3'b001, 32'h0,    32'h40,  32'h1234, 5'd0, 1'b0, 2,   32'h0);        // store, 3-cycle
    issue(2'b11, 3'b010, 32'h0,    32'h80,  32'h0,    5'd9, 1'b0, 999, 32'h55AA55AA); // timeout
    issue(2'b11, 3'b010, 32'h0,    32'h100, 32'h0,    5'd3, 1'b0, 0,   32'h1);        // back in IDLE
    issue(2'b11, 3'b010, 32'h0,    32'h102, 32'h0,    5'd6, 1'b0, 0,   32'h2);        // misaligned
    issue(2'b00, 3'b100, 32'h2000, 32'h0,   32'h0,    5'd0, 1'b1, 0,   32'h0);        // branch taken
    issue(2'b00, 3'b100, 32'h2000, 32'h0,   32'h0,    5'd0, 1'b0, 0,   32'h0);        // not taken
    issue(2'b11, 3'b011, 32'h0,    32'h8,   32'hCAFE, 5'd4, 1'b0, 1,   32'hFFFF0000); // read+write
    issue(2'b10, 3'b001, 32'h0,    32'hC,   32'h77,   5'd2, 1'b0, TO,  32'h0);        // ack on last cycle
    issue(2'b10, 3'b000, 32'h0,    32'h3,   32'h0,    5'd8, 1'b0, 0,   32'h0);        // ALU op, odd address

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      m   = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel < 6)      lat = $urandom_range(0, 3);
      else if (sel < 8) lat = $urandom_range(TO - 1, TO + 1);
      else              lat = 0;
      issue(2'($urandom_range(0, 3)), m, $urandom, a, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), lat, $urandom);
    end
    issue(2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 0, 32'h0); // NOP to settle

    // Reset while waiting: four stall cycles, then abort
    @(posedge clk); #2;
    WB_in = 2'b11; MEM_in = 3'b010; alu_in = 32'h200; WN_in = 5'd7; dm_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wait_stall", 32'(stall), 32'h1);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("abort_dm_req",   32'(dm_req),   32'h0);
    chk("abort_stall",    32'(stall),    32'h0);
    chk("abort_WB_out",   32'(WB_out),   32'h0);
    chk("abort_RD_out",   RD_out,        32'h0);
    chk("abort_alu_out",  alu_out,       32'h0);
    chk("abort_WN_out",   32'(WN_out),   32'h0);
    chk("abort_bus_err",  32'(bus_err),  32'h0);
    MEM_in = 3'b000;
    @(posedge clk); #2;
    chk("abort_no_bus_err", 32'(bus_err), 32'h0);
    @(negedge clk); rst = 1'b1;
    issue(2'b11, 3'b010, 32'h0, 32'h100, 32'h0, 5'd5, 1'b0, 0, 32'hDEADBEEF);
    issue(2'b00, 3'b000, 32'h0, 32'h0,   32'h0, 5'd0, 1'b0, 0, 32'h0);
    @(posedge clk); #3;
    if (cq.size() != 0 || rq.size() != 0)
      chk("scoreboard_drain", 32'(cq.size() + rq.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
